// File: rtl/buffer_seq_pkg.sv
// Shared types and default sizes for the pattern buffer sequencer.
package buffer_seq_pkg;

    localparam int NO_BUFS_DEFAULT   = 8;
    localparam int SEQ_DEPTH_DEFAULT = 8;
    localparam int DWELL_W_DEFAULT   = 8;

    localparam int BUF_W   = $clog2(NO_BUFS_DEFAULT);
    localparam int IDX_W   = $clog2(SEQ_DEPTH_DEFAULT);
    localparam int DWELL_W = DWELL_W_DEFAULT;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // One sequence step: which buffer to show and for how many frames (minus one).
    typedef struct packed {
        logic [BUF_W-1:0]   bufIdx;
        logic [DWELL_W-1:0] dwell;
    } seq_entry_t;

endpackage

// File: rtl/buffer_seq_ctrl_if.sv
// Configuration, sequencing and field-write signals of the buffer sequencer.
// master = processor/bench side, slave = the sequencer.
interface buffer_seq_ctrl_if #(
    parameter int BUF_W   = 3,
    parameter int IDX_W   = 3,
    parameter int DWELL_W = 8
);
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_addr;
    logic [BUF_W-1:0]   cfg_buf;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [IDX_W-1:0]   seq_len;
    logic               loop_en;
    logic               start;
    logic               stop;
    logic               frame_tick;
    logic [BUF_W-1:0]   bufp;
    logic               field_write;
    logic [BUF_W-1:0]   buffer_select;
    logic [IDX_W-1:0]   seq_idx;
    logic               busy;
    logic               buf_change;
    logic               seq_done;
    logic               field_write_q;
    logic               wr_conflict;

    modport master (
        output cfg_we, cfg_addr, cfg_buf, cfg_dwell, seq_len, loop_en,
               start, stop, frame_tick, bufp, field_write,
        input  buffer_select, seq_idx, busy, buf_change, seq_done,
               field_write_q, wr_conflict
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_buf, cfg_dwell, seq_len, loop_en,
               start, stop, frame_tick, bufp, field_write,
        output buffer_select, seq_idx, busy, buf_change, seq_done,
               field_write_q, wr_conflict
    );
endinterface

// File: rtl/buffer_seq_table.sv
// Sequence table: register file with one synchronous write port and one
// asynchronous read port. A read of an entry being written returns the old data.
module buffer_seq_table
    import buffer_seq_pkg::*;
#(
    parameter int SEQ_DEPTH = SEQ_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  seq_entry_t       wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output seq_entry_t       rdata_o
);

    seq_entry_t entries_q [SEQ_DEPTH];

    // Entry storage, cleared to buffer 0 / dwell 0 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (we_i) begin
            entries_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = entries_q[raddr_i];

endmodule

// File: rtl/buffer_seq_ctrl.sv
// Buffer sequencer: steps buffer_select through the programmed table, holding
// each entry for dwell+1 frame ticks. Optional write protection of the buffer
// on display is enabled with the BUFSEQ_WRPROT_EN macro.
module buffer_seq_ctrl
    import buffer_seq_pkg::*;
#(
    parameter int NO_BUFS   = NO_BUFS_DEFAULT,
    parameter int SEQ_DEPTH = SEQ_DEPTH_DEFAULT,
    parameter int DWELL_W   = DWELL_W_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    buffer_seq_ctrl_if.slave  bus
);

    localparam int SelW = $clog2(NO_BUFS);
    localparam int IdxW = $clog2(SEQ_DEPTH);

    seq_state_t          state_q, state_d;
    logic [SelW-1:0]     bufSel_q, bufSel_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     len_q, len_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic                change_q, change_d;
    logic                done_q, done_d;
    logic [IdxW-1:0]     rdAddr;
    seq_entry_t          rdEntry;
    seq_entry_t          wrEntry;
    logic                busy;
    logic                conflict;

    assign wrEntry = '{bufIdx: bus.cfg_buf, dwell: bus.cfg_dwell};

    buffer_seq_table #(
        .SEQ_DEPTH (SEQ_DEPTH)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (bus.cfg_we),
        .waddr_i (bus.cfg_addr),
        .wdata_i (wrEntry),
        .raddr_i (rdAddr),
        .rdata_o (rdEntry)
    );

    // Next-state logic: stop beats start, start beats frame_tick, and the
    // read address always points at the entry that would be loaded next.
    always_comb begin
        state_d  = state_q;
        bufSel_d = bufSel_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        change_d = 1'b0;
        done_d   = 1'b0;
        rdAddr   = idx_q + 1'b1;

        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.start) begin
            rdAddr   = '0;
            len_d    = bus.seq_len;
            bufSel_d = rdEntry.bufIdx;
            cnt_d    = rdEntry.dwell;
            idx_d    = '0;
            change_d = 1'b1;
            state_d  = RUN;
        end else if (state_q == RUN && bus.frame_tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (idx_q < len_q) begin
                bufSel_d = rdEntry.bufIdx;
                cnt_d    = rdEntry.dwell;
                idx_d    = idx_q + 1'b1;
                change_d = 1'b1;
            end else if (bus.loop_en) begin
                rdAddr   = '0;
                bufSel_d = rdEntry.bufIdx;
                cnt_d    = rdEntry.dwell;
                idx_d    = '0;
                change_d = 1'b1;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bufSel_q <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            change_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bufSel_q <= bufSel_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);

`ifdef BUFSEQ_WRPROT_EN
    assign conflict = bus.field_write & busy & (bus.bufp == bufSel_q);
    assign bus.field_write_q = bus.field_write & ~conflict;
`else
    assign conflict = 1'b0;
    assign bus.field_write_q = bus.field_write;
`endif

    assign bus.wr_conflict   = conflict;
    assign bus.buffer_select = bufSel_q;
    assign bus.seq_idx       = idx_q;
    assign bus.busy          = busy;
    assign bus.buf_change    = change_q;
    assign bus.seq_done      = done_q;

endmodule

// File: tb/tb_buffer_seq_ctrl.sv
// Directed bench for buffer_seq_ctrl. Expected outputs are queued as each
// step is driven and compared one cycle later, just after the clock edge.
module tb_buffer_seq_ctrl;

    typedef struct {
        string      tag;
        logic [2:0] sel;
        logic [2:0] idx;
        logic       busy;
        logic       chg;
        logic       done;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checkCount = 0;
    int   errorCount = 0;
    exp_t expQ[$];

    buffer_seq_ctrl_if #(.BUF_W(3), .IDX_W(3), .DWELL_W(8)) bus ();

    buffer_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        e = expQ.pop_front();
        checkValue({e.tag, ".sel"},  8'(bus.buffer_select), 8'(e.sel));
        checkValue({e.tag, ".idx"},  8'(bus.seq_idx),       8'(e.idx));
        checkValue({e.tag, ".busy"}, 8'(bus.busy),          8'(e.busy));
        checkValue({e.tag, ".chg"},  8'(bus.buf_change),    8'(e.chg));
        checkValue({e.tag, ".done"}, 8'(bus.seq_done),      8'(e.done));
    endtask

    // Drive one cycle of pulses, queue what the DUT must show after the edge.
    task automatic applyStimulus(input string tag, input logic st, input logic sp, input logic ft,
                                 input logic [2:0] eSel, input logic [2:0] eIdx,
                                 input logic eBusy, input logic eChg, input logic eDone);
        exp_t e;
        e = '{tag: tag, sel: eSel, idx: eIdx, busy: eBusy, chg: eChg, done: eDone};
        bus.start      = st;
        bus.stop       = sp;
        bus.frame_tick = ft;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.frame_tick = 1'b0;
        bus.cfg_we     = 1'b0;
        checkOutput();
    endtask

    task automatic cfgWrite(input logic [2:0] addr, input logic [2:0] b, input logic [7:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_buf   = b;
        bus.cfg_dwell = d;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_buf     = '0;
        bus.cfg_dwell   = '0;
        bus.seq_len     = '0;
        bus.loop_en     = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.frame_tick  = 1'b0;
        bus.bufp        = '0;
        bus.field_write = 1'b0;

        // Reset state
        #12;
        expQ.push_back('{tag: "reset", sel: 3'd0, idx: 3'd0, busy: 1'b0, chg: 1'b0, done: 1'b0});
        checkOutput();
        checkValue("reset.fwq", 8'(bus.field_write_q), 8'd0);
        checkValue("reset.wc",  8'(bus.wr_conflict),   8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One-shot run: entry0 {3,0}, entry1 {5,2}
        cfgWrite(3'd0, 3'd3, 8'd0);
        cfgWrite(3'd1, 3'd5, 8'd2);
        bus.seq_len = 3'd1;
        bus.loop_en = 1'b0;
        applyStimulus("os.start", 1, 0, 0, 3'd3, 3'd0, 1, 1, 0);
        applyStimulus("os.hold",  0, 0, 0, 3'd3, 3'd0, 1, 0, 0);
        applyStimulus("os.t1",    0, 0, 1, 3'd5, 3'd1, 1, 1, 0);
        applyStimulus("os.t2",    0, 0, 1, 3'd5, 3'd1, 1, 0, 0);
        applyStimulus("os.t3",    0, 0, 1, 3'd5, 3'd1, 1, 0, 0);
        applyStimulus("os.t4",    0, 0, 1, 3'd5, 3'd1, 0, 0, 1);
        applyStimulus("os.after", 0, 0, 0, 3'd5, 3'd1, 0, 0, 0);

        // Looping run: 3,5,5,5,3,5,...
        bus.loop_en = 1'b1;
        applyStimulus("lp.start", 1, 0, 0, 3'd3, 3'd0, 1, 1, 0);
        applyStimulus("lp.t1",    0, 0, 1, 3'd5, 3'd1, 1, 1, 0);
        applyStimulus("lp.t2",    0, 0, 1, 3'd5, 3'd1, 1, 0, 0);
        applyStimulus("lp.t3",    0, 0, 1, 3'd5, 3'd1, 1, 0, 0);
        applyStimulus("lp.wrap",  0, 0, 1, 3'd3, 3'd0, 1, 1, 0);
        applyStimulus("lp.t5",    0, 0, 1, 3'd5, 3'd1, 1, 1, 0);

        // Stop two ticks into entry 1
        applyStimulus("st.t1",    0, 0, 1, 3'd5, 3'd1, 1, 0, 0);
        applyStimulus("st.t2",    0, 0, 1, 3'd5, 3'd1, 1, 0, 0);
        applyStimulus("st.stop",  0, 1, 0, 3'd5, 3'd1, 0, 0, 0);
        applyStimulus("st.idle",  0, 0, 1, 3'd5, 3'd1, 0, 0, 0);
        applyStimulus("st.both",  1, 1, 0, 3'd5, 3'd1, 0, 0, 0);

        // Rewrite entry 1 while entry 0 is active
        bus.loop_en = 1'b0;
        applyStimulus("wr.start", 1, 0, 1, 3'd3, 3'd0, 1, 1, 0);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'd1;
        bus.cfg_buf   = 3'd7;
        bus.cfg_dwell = 8'd0;
        applyStimulus("wr.write", 0, 0, 0, 3'd3, 3'd0, 1, 0, 0);
        applyStimulus("wr.load7", 0, 0, 1, 3'd7, 3'd1, 1, 1, 0);
        applyStimulus("wr.done",  0, 0, 1, 3'd7, 3'd1, 0, 0, 1);

        // Write entry 0 in its own load cycle: old {3,0} is used
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'd0;
        bus.cfg_buf   = 3'd6;
        bus.cfg_dwell = 8'd1;
        applyStimulus("rw.start", 1, 0, 0, 3'd3, 3'd0, 1, 1, 0);
        applyStimulus("rw.t1",    0, 0, 1, 3'd7, 3'd1, 1, 1, 0);
        applyStimulus("rw.done",  0, 0, 1, 3'd7, 3'd1, 0, 0, 1);
        applyStimulus("rw.new",   1, 0, 0, 3'd6, 3'd0, 1, 1, 0);
        applyStimulus("rw.dec",   0, 0, 1, 3'd6, 3'd0, 1, 0, 0);
        applyStimulus("rw.next",  0, 0, 1, 3'd7, 3'd1, 1, 1, 0);

        // Field write against the displayed buffer 5
        cfgWrite(3'd1, 3'd5, 8'd2);
        applyStimulus("fw.start", 1, 0, 0, 3'd6, 3'd0, 1, 1, 0);
        applyStimulus("fw.dec",   0, 0, 1, 3'd6, 3'd0, 1, 0, 0);
        applyStimulus("fw.sel5",  0, 0, 1, 3'd5, 3'd1, 1, 1, 0);
        bus.bufp        = 3'd5;
        bus.field_write = 1'b1;
        #1;
`ifdef BUFSEQ_WRPROT_EN
        checkValue("fw.same.fwq", 8'(bus.field_write_q), 8'd0);
        checkValue("fw.same.wc",  8'(bus.wr_conflict),   8'd1);
`else
        checkValue("fw.same.fwq", 8'(bus.field_write_q), 8'd1);
        checkValue("fw.same.wc",  8'(bus.wr_conflict),   8'd0);
`endif
        bus.bufp = 3'd2;
        #1;
        checkValue("fw.other.fwq", 8'(bus.field_write_q), 8'd1);
        checkValue("fw.other.wc",  8'(bus.wr_conflict),   8'd0);
        bus.field_write = 1'b0;
        #1;
        checkValue("fw.none.fwq", 8'(bus.field_write_q), 8'd0);

        // Asynchronous reset in the middle of a run
        rst_n = 1'b0;
        #1;
        expQ.push_back('{tag: "arst", sel: 3'd0, idx: 3'd0, busy: 1'b0, chg: 1'b0, done: 1'b0});
        checkOutput();
        checkValue("arst.wc", 8'(bus.wr_conflict), 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.seq_len = 3'd0;
        applyStimulus("cl.start", 1, 0, 0, 3'd0, 3'd0, 1, 1, 0);
        applyStimulus("cl.done",  0, 0, 1, 3'd0, 3'd0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/buffer_seq_ctrl.md
# buffer_seq_ctrl

Sequencer that drives `buffer_select` of the 8-way pattern buffer bank, stepping through a programmable list of buffer indices. Each entry is held for a programmable number of frame ticks. It sits between the processor-side configuration registers and the buffer bank. It optionally blocks field writes aimed at the buffer currently on display.

## Interface
Parameters:
- `NO_BUFS`, 8: number of pattern buffers; index width `BUF_W` = 3
- `SEQ_DEPTH`, 8: sequence table entries; index width `IDX_W` = 3
- `DWELL_W`, 8: dwell counter width

Ports:
- `clk` in 1: sole clock
- `rst_n` in 1: asynchronous, active-low reset
- `cfg_we` in 1: write one sequence table entry
- `cfg_addr` in IDX_W: entry to write
- `cfg_buf` in BUF_W: buffer index for the entry
- `cfg_dwell` in DWELL_W: dwell for the entry, in frames minus one
- `seq_len` in IDX_W: index of the last valid entry
- `loop_en` in 1: wrap to entry 0 after the last entry
- `start` in 1: single-cycle pulse, begin the sequence
- `stop` in 1: single-cycle pulse, abort the sequence
- `frame_tick` in 1: single-cycle frame boundary strobe
- `bufp` in BUF_W: target buffer of the pending field write
- `field_write` in 1: raw field write request
- `buffer_select` out BUF_W: buffer index presented to the bank
- `seq_idx` out IDX_W: active entry index
- `busy` out 1: sequence running
- `buf_change` out 1: one-cycle pulse on each entry load
- `seq_done` out 1: one-cycle pulse on natural completion
- `field_write_q` out 1: gated field write into the bank
- `wr_conflict` out 1: field write blocked this cycle

## Operation
- Table: `SEQ_DEPTH` registered entries of {buf, dwell}.
  - Written on `cfg_we` at any time.
  - An entry load in the same cycle as a write to that entry uses the old contents.
- States: IDLE and RUN.
- IDLE, on `start`:
  - Latch `seq_len`.
  - Load entry 0: `buffer_select`=buf[0], counter=dwell[0], `seq_idx`=0.
  - Go to RUN, `busy`=1, pulse `buf_change`.
- RUN, on `frame_tick`:
  - Counter ≠ 0: decrement it.
  - Counter = 0 and `seq_idx` < latched length: load entry `seq_idx`+1.
  - Counter = 0, `seq_idx` = latched length, `loop_en`=1: load entry 0.
  - Counter = 0, `seq_idx` = latched length, `loop_en`=0: go to IDLE, `busy`=0, pulse `seq_done`. `buffer_select` and `seq_idx` hold their last values.
- Entry hold time: an entry with dwell D stays active for D+1 frame ticks.
- `loop_en` is sampled live at the wrap decision. `seq_len` is sampled only at `start`.
- `stop` (any state): go to IDLE next cycle. `busy`=0, no `seq_done`, `buffer_select` holds.
- `start` in RUN: restart from entry 0 exactly as from IDLE.
- `start` and `stop` in the same cycle: `stop` wins.
- `frame_tick` in the same cycle as `start`: ignored; the counter loads with the full dwell.
- Counter arithmetic: unsigned DWELL_W bits, never underflows (decrement only when ≠ 0).
- Reset values:
  - Table cleared to buf=0, dwell=0.
  - `buffer_select`=0, `seq_idx`=0, counter=0.
  - `busy`=0, `buf_change`=0, `seq_done`=0, `field_write_q`=0, `wr_conflict`=0.
  - State IDLE.
- Reset asserted mid-sequence forces all of the above immediately (asynchronously).

## Timing
- `start` at cycle N: `busy`, `buffer_select`, `seq_idx` updated at N+1; `buf_change` high during N+1 only.
- `frame_tick` at cycle M causing a load or completion: new outputs at M+1; `buf_change` or `seq_done` high during M+1 only.
- `stop` at cycle N: `busy` low at N+1.
- `field_write_q` and `wr_conflict` are combinational from `field_write`, `bufp`, `busy`, `buffer_select`. No latency.
- All other outputs are registered.

## Configuration
- `BUFSEQ_WRPROT_EN` defined:
  - `wr_conflict` = `field_write` & `busy` & (`bufp` == `buffer_select`).
  - `field_write_q` = `field_write` & ~`wr_conflict`.
- Undefined:
  - `field_write_q` = `field_write`.
  - `wr_conflict` tied 0.
  - No comparator logic is generated.

## Structure
- Package `buffer_seq_pkg`:
  - `seq_state_t` enum {IDLE, RUN}.
  - `seq_entry_t` struct {buf[BUF_W], dwell[DWELL_W]}.
  - Default constants for `NO_BUFS`, `SEQ_DEPTH`, `DWELL_W`.
- Sub-module `buffer_seq_table`: register file, one synchronous write port, one asynchronous read port indexed by the next entry, async active-low clear.
- FSM, counter and write-protect logic stay in `buffer_seq_ctrl`.

## Test plan
- Reset, then check every output is 0. Program entries {3,0},{5,2}, `seq_len`=1, `loop_en`=0, pulse `start` -> `buffer_select`=3 on the next cycle. After 1 tick -> 5. After 3 more ticks -> `seq_done` pulse, `busy`=0, `buffer_select` stays 5.
- Same table with `loop_en`=1 -> select sequence 3,5,5,5,3,5,... and `buf_change` pulses once per load, never `seq_done`.
- Pulse `stop` two ticks into entry 1 -> `busy`=0 next cycle, no `seq_done`, `buffer_select`=5 held. Pulse `start` and `stop` together -> remains IDLE.
- Write entry 1 = {7,0} while entry 0 is active -> entry 1 loads 7. Write to the active entry in its load cycle -> old value used.
- With `BUFSEQ_WRPROT_EN`, RUN with `buffer_select`=5:
  - `bufp`=5, `field_write`=1 -> `field_write_q`=0, `wr_conflict`=1.
  - `bufp`=2 -> `field_write_q`=1.
  - Without the macro, `bufp`=5 -> `field_write_q`=1.
- Assert `rst_n` low mid-RUN -> all outputs 0 asynchronously, state IDLE. Table reads back cleared on the next `start`, so `buffer_select`=0.
